// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry byte FIFO; otherwise a single holding register is used.
module uart_tx_param #(
    parameter int CLK_DIV    = 1042,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_tx_data,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_led_tx,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int CW = $clog2(CLK_DIV);
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);
    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cyc_reg, cyc_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg;
    logic            par_reg;
    logic            tx_reg, tx_next;
    logic            ready_en_reg;
    logic            bit_end;
    logic            avail;
    logic            push;
    logic            pop;
    logic [7:0]      head_data;

    assign bit_end = (cyc_reg == CW'(CLK_DIV - 1));
    assign push    = i_valid && o_ready;
    // A byte leaves storage exactly when the FSM enters START from IDLE or STOP.
    assign pop     = (state_next == ST_START) && (state_reg != ST_START);

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        if (state_reg == ST_IDLE) begin
            cyc_next = '0;
            bit_next = '0;
            if (avail) begin
                state_next = ST_START;
            end
        end else if (!bit_end) begin
            cyc_next = cyc_reg + CW'(1);
        end else begin
            cyc_next = '0;
            case (state_reg)
                ST_START: begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
                ST_DATA: begin
                    if (bit_reg == 3'(DATA_BITS - 1)) begin
                        state_next = PAR_EN ? ST_PARITY : ST_STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
                ST_PARITY: begin
                    state_next = ST_STOP;
                    bit_next   = '0;
                end
                ST_STOP: begin
                    if (bit_reg == 3'(STOP_BITS - 1)) begin
                        state_next = avail ? ST_START : ST_IDLE;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The line value is chosen from the state being entered so it lines up with that state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_reg[bit_next];
            ST_PARITY: tx_next = par_reg;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            cyc_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cyc_reg      <= cyc_next;
            bit_reg      <= bit_next;
            tx_reg       <= tx_next;
            ready_en_reg <= 1'b1;
            if (pop) begin
                shift_reg <= head_data & DATA_MASK;
                par_reg   <= (^(head_data & DATA_MASK)) ^ PAR_ODD;
            end
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] count_reg;

    assign o_ready   = ready_en_reg && (count_reg != LW'(FIFO_DEPTH));
    assign avail     = (count_reg != '0);
    assign head_data = mem[rd_ptr_reg];
    assign o_level   = count_reg;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + LW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - LW'(1);
            end
        end
    end
`else
    logic [7:0] hold_reg;
    logic       pending_reg;

    assign o_ready   = ready_en_reg && (state_reg == ST_IDLE) && !pending_reg;
    assign avail     = pending_reg;
    assign head_data = hold_reg;
    assign o_level   = '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_reg    <= '0;
            pending_reg <= 1'b0;
        end else if (push) begin
            hold_reg    <= i_data;
            pending_reg <= 1'b1;
        end else if (pop) begin
            pending_reg <= 1'b0;
        end
    end
`endif

    assign o_tx_data = tx_reg;
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_led_tx  = o_busy;
    assign o_done    = (state_reg == ST_STOP) && (bit_reg == 3'(STOP_BITS - 1)) && bit_end;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three differently configured instances driven
// with directed and random bytes, compared cycle by cycle against a bit-list frame model.
module tb_uart_tx_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [3];
    logic       valid [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       done  [3];
    logic       led   [3];
    logic [2:0] level [3];

    int total = 0;
    int bad   = 0;

    int cfg_div  [3] = '{4, 3, 5};
    int cfg_nb   [3] = '{8, 7, 8};
    int cfg_par  [3] = '{0, 1, 2};
    int cfg_stop [3] = '{1, 1, 2};

    logic model_bits [$];

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_valid(valid[0]), .i_data(data[0]),
        .o_ready(ready[0]), .o_tx_data(tx[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_led_tx(led[0]), .o_level(level[0]));

    uart_tx_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_valid(valid[1]), .i_data(data[1]),
        .o_ready(ready[1]), .o_tx_data(tx[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_led_tx(led[1]), .o_level(level[1]));

    uart_tx_param #(.CLK_DIV(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .i_clk(clk), .i_rst(rst[2]), .i_valid(valid[2]), .i_data(data[2]),
        .o_ready(ready[2]), .o_tx_data(tx[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_led_tx(led[2]), .o_level(level[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Appends the serial bit list of one frame: 0, data LSB first, parity, stop bits.
    task automatic append_frame(input int u, input logic [7:0] b);
        logic p;
        p = 1'b0;
        model_bits.push_back(1'b0);
        for (int i = 0; i < cfg_nb[u]; i++) begin
            model_bits.push_back(b[i]);
            p = p ^ b[i];
        end
        if (cfg_par[u] == 1) model_bits.push_back(p);
        else if (cfg_par[u] == 2) model_bits.push_back(~p);
        for (int i = 0; i < cfg_stop[u]; i++) model_bits.push_back(1'b1);
    endtask

    task automatic check_reset_outputs(input int u, input string tag);
        chk({tag, "_tx"}, 32'(tx[u]), 32'd1);
        chk({tag, "_busy"}, 32'(busy[u]), 32'd0);
        chk({tag, "_done"}, 32'(done[u]), 32'd0);
        chk({tag, "_led"}, 32'(led[u]), 32'd0);
        chk({tag, "_ready"}, 32'(ready[u]), 32'd0);
        chk({tag, "_level"}, 32'(level[u]), 32'd0);
    endtask

    // Sends one byte and checks every cycle; rst_at > 0 pulses reset mid-frame at that iteration.
    task automatic send_one(input int u, input logic [7:0] b, input int rst_at);
        int div, len, n, fc;
        logic exp_tx, exp_busy, exp_done;
        div = cfg_div[u];
        model_bits.delete();
        append_frame(u, b);
        len = model_bits.size();
        n = 2 + len * div + 3;
        $display("frame dut=%0d byte=%02h bits=%0d rst_at=%0d", u, b, len, rst_at);
        @(negedge clk);
        chk("ready_before_offer", 32'(ready[u]), 32'd1);
        valid[u] = 1'b1;
        data[u]  = b;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                valid[u] = 1'b0;
                data[u]  = ~b;
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                check_reset_outputs(u, "midrst");
                rst[u] = 1'b0;
                @(negedge clk);
                chk("ready_after_midrst", 32'(ready[u]), 32'd1);
                chk("busy_after_midrst", 32'(busy[u]), 32'd0);
                chk("tx_after_midrst", 32'(tx[u]), 32'd1);
                chk("done_after_midrst", 32'(done[u]), 32'd0);
                return;
            end
            fc = k - 2;
            if (fc >= 0 && fc < len * div) begin
                exp_tx   = model_bits[fc / div];
                exp_busy = 1'b1;
                exp_done = (fc == len * div - 1);
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end
            chk("tx", 32'(tx[u]), 32'(exp_tx));
            chk("busy", 32'(busy[u]), 32'(exp_busy));
            chk("led", 32'(led[u]), 32'(exp_busy));
            chk("done", 32'(done[u]), 32'(exp_done));
`ifndef UART_TX_FIFO_EN
            chk("level_tied", 32'(level[u]), 32'd0);
            if (k == 1 || (fc >= 0 && fc < len * div))
                chk("ready_low_busy", 32'(ready[u]), 32'd0);
            if (k >= 2 + len * div)
                chk("ready_high_idle", 32'(ready[u]), 32'd1);
            // Offer a stray byte while not ready; it must never be sent.
            if (k == 4) begin
                valid[u] = 1'b1;
                data[u]  = 8'($urandom);
            end
            if (k == 6) valid[u] = 1'b0;
`endif
            if (k == rst_at) rst[u] = 1'b1;
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic fifo_burst();
        logic [7:0] offered [6];
        int nacc, n, fc, len;
        logic exp_tx, exp_busy, exp_done;
        nacc = 0;
        model_bits.delete();
        for (int i = 0; i < 6; i++) offered[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) append_frame(0, offered[i]);
        len = 40;
        n = 2 + 5 * len + 3;
        $display("burst dut=0 bytes=%02h %02h %02h %02h %02h %02h", offered[0], offered[1],
                 offered[2], offered[3], offered[4], offered[5]);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < 6) begin
                if (ready[0]) nacc++;
                if (k == 5) begin
                    chk("fifo_full_ready", 32'(ready[0]), 32'd0);
                    chk("fifo_full_level", 32'(level[0]), 32'd4);
                end
                valid[0] = 1'b1;
                data[0]  = offered[k];
            end else begin
                valid[0] = 1'b0;
            end
            if (k == 6) chk("fifo_accepted", 32'(nacc), 32'd5);
            if (k >= 1) begin
                fc = k - 2;
                if (fc >= 0 && fc < 5 * len) begin
                    exp_tx   = model_bits[fc / 4];
                    exp_busy = 1'b1;
                    exp_done = ((fc % len) == len - 1);
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                end
                chk("burst_tx", 32'(tx[0]), 32'(exp_tx));
                chk("burst_busy", 32'(busy[0]), 32'(exp_busy));
                chk("burst_done", 32'(done[0]), 32'(exp_done));
                if (fc >= 0 && fc < 5 * len && (fc % len) == len - 1)
                    chk("burst_level", 32'(level[0]), 32'(4 - fc / len));
                if (fc >= 5 * len) chk("burst_level_empty", 32'(level[0]), 32'd0);
            end
        end
    endtask
`endif

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u]   = 1'b1;
            valid[u] = 1'b0;
            data[u]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset_outputs(u, "reset");
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) chk("ready_after_reset", 32'(ready[u]), 32'd1);

        send_one(0, 8'h41, -1);
        send_one(1, 8'h83, -1);
        send_one(2, 8'h01, -1);
        send_one(0, 8'hA5, 15);
        send_one(0, 8'h5A, -1);
`ifdef UART_TX_FIFO_EN
        fifo_burst();
`endif
        for (int r = 0; r < 4; r++) begin
            for (int u = 0; u < 3; u++) send_one(u, 8'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
